// File: rtl/wb_stream_reader_master_pkg.sv
// Shared encodings for the stream reader bus-master engine: FSM states and Wishbone
// cycle-type / burst-type codes. No logic; latency and backpressure live in the users.
package wb_stream_reader_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_stream_reader_master_if.sv
// Wishbone read-master bus plus the outgoing valid/ready word stream of the reader engine.
// Pure wiring; the master modport is the engine side, slave is the memory/sink side.
interface wb_stream_reader_master_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
);
    logic [WB_AW-1:0]   m_adr_o;
    logic               m_cyc_o;
    logic               m_stb_o;
    logic               m_we_o;
    logic [WB_DW/8-1:0] m_sel_o;
    logic [2:0]         m_cti_o;
    logic [1:0]         m_bte_o;
    logic [WB_DW-1:0]   m_dat_i;
    logic               m_ack_i;
    logic               m_err_i;

    logic [WB_DW-1:0]   stream_data_o;
    logic               stream_valid_o;
    logic               stream_ready_i;

    modport master (
        output m_adr_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_cti_o, m_bte_o,
        input  m_dat_i, m_ack_i, m_err_i,
        output stream_data_o, stream_valid_o,
        input  stream_ready_i
    );

    modport slave (
        input  m_adr_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_cti_o, m_bte_o,
        output m_dat_i, m_ack_i, m_err_i,
        input  stream_data_o, stream_valid_o,
        output stream_ready_i
    );

endinterface

// File: rtl/wb_stream_reader_master_stream_fifo.sv
// Synchronous first-word-fall-through FIFO: head word visible with zero read latency.
// Push when full and pop when empty are dropped; simultaneous push/pop keeps the level.
module wb_stream_reader_master_stream_fifo #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    localparam int            DEPTH   = 1 << AW;
    localparam int            PW      = AW + 1;
    localparam logic [AW:0]   DEPTH_L = PW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (level_o == DEPTH_L);
    assign empty_o   = (level_o == '0);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign wr_ptr_d  = wr_ptr_q + PW'(do_push);
    assign rd_ptr_d  = rd_ptr_q + PW'(do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/wb_stream_reader_master.sv
// Reads buf_size words from start_adr with incrementing Wishbone bursts into a FWFT FIFO and
// streams them out (zero read latency); a burst starts only once the FIFO has room for all of it.
module wb_stream_reader_master
    import wb_stream_reader_master_pkg::*;
#(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 5
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      enable,
    input  logic [WB_AW-1:0]          start_adr,
    input  logic [WB_AW-1:0]          buf_size,
    input  logic [WB_AW-1:0]          burst_size,
    output logic                      busy,
    output logic [WB_DW-1:0]          tx_cnt,
    output logic                      error,
    wb_stream_reader_master_if.master bus
);
    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam int               BW       = FIFO_AW + 1;
    localparam int               BYTES    = WB_DW / 8;
    localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(BYTES);
    localparam logic [WB_AW-1:0] ADR_LSB  = WB_AW'(BYTES - 1);
    localparam logic [WB_AW-1:0] DEPTH_W  = WB_AW'(DEPTH);
    localparam logic [WB_AW-1:0] ONE_W    = WB_AW'(1);
    localparam logic [BW-1:0]    DEPTH_B  = BW'(DEPTH);
    localparam logic [BW-1:0]    ONE_B    = BW'(1);
    localparam logic [BW-1:0]    TWO_B    = BW'(2);

    state_e           state_q;
    logic             enable_q;
    logic [WB_AW-1:0] adr_q;
    logic [WB_AW-1:0] remaining_q;
    logic [BW-1:0]    burst_q;
    logic [BW-1:0]    beats_q;
    logic             cyc_q;
    logic [2:0]       cti_q;
    logic             busy_q;
    logic             error_q;
    logic [WB_DW-1:0] tx_cnt_q;

    logic [BW-1:0]    burst_d;
    logic [BW-1:0]    beat_cnt;
    logic [BW-1:0]    fifo_level;
    logic [BW-1:0]    fifo_free;
    logic             fifo_full;
    logic             fifo_empty;
    logic             start;
    logic             push;
    logic             pop;
    logic             last_pop;

    always_comb begin
        burst_d = DEPTH_B;
        if (burst_size == '0) begin
            burst_d = ONE_B;
        end else if (burst_size <= DEPTH_W) begin
            burst_d = burst_size[BW-1:0];
        end
    end

    assign beat_cnt  = (remaining_q < WB_AW'(burst_q)) ? remaining_q[BW-1:0] : burst_q;
    assign fifo_free = DEPTH_B - fifo_level;
    assign start     = enable & ~enable_q & (state_q == ST_IDLE) & (buf_size != '0);
    assign push      = (state_q == ST_BURST) & cyc_q & bus.m_ack_i & ~bus.m_err_i & ~fifo_full;
    assign pop       = ~fifo_empty & bus.stream_ready_i;
    assign last_pop  = fifo_empty | ((fifo_level == ONE_B) & pop);

    wb_stream_reader_master_stream_fifo #(
        .DW (WB_DW),
        .AW (FIFO_AW)
    ) u_stream_fifo (
        .clk_i      (wb_clk_i),
        .rst_n_i    (wb_rst_n_i),
        .push_i     (push),
        .push_dat_i (bus.m_dat_i),
        .pop_i      (pop),
        .pop_dat_o  (bus.stream_data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            // Held high through reset so an enable level that survives reset is not a new start.
            enable_q    <= 1'b1;
            adr_q       <= '0;
            remaining_q <= '0;
            burst_q     <= ONE_B;
            beats_q     <= '0;
            cyc_q       <= 1'b0;
            cti_q       <= CTI_CLASSIC;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            tx_cnt_q    <= '0;
        end else begin
            enable_q <= enable;
            if (pop) begin
                tx_cnt_q <= tx_cnt_q + WB_DW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        adr_q       <= start_adr & ~ADR_LSB;
                        remaining_q <= buf_size;
                        burst_q     <= burst_d;
                        tx_cnt_q    <= '0;
                        error_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Whole burst must fit, so every ack can be absorbed without stalling.
                    if (fifo_free >= beat_cnt) begin
                        beats_q <= beat_cnt;
                        cyc_q   <= 1'b1;
                        cti_q   <= (beat_cnt == ONE_B) ? CTI_EOB : CTI_INCR;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (bus.m_err_i) begin
                        cyc_q       <= 1'b0;
                        cti_q       <= CTI_CLASSIC;
                        error_q     <= 1'b1;
                        remaining_q <= '0;
                        state_q     <= ST_DRAIN;
                    end else if (bus.m_ack_i) begin
                        adr_q       <= adr_q + ADR_STEP;
                        remaining_q <= remaining_q - ONE_W;
                        beats_q     <= beats_q - ONE_B;
                        if (beats_q == ONE_B) begin
                            cyc_q   <= 1'b0;
                            cti_q   <= CTI_CLASSIC;
                            state_q <= (remaining_q == ONE_W) ? ST_DRAIN : ST_WAIT;
                        end else if (beats_q == TWO_B) begin
                            cti_q <= CTI_EOB;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave on the very edge that hands over the last word.
                    if (last_pop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.m_adr_o        = adr_q;
    assign bus.m_cyc_o        = cyc_q;
    assign bus.m_stb_o        = cyc_q;
    assign bus.m_we_o         = 1'b0;
    assign bus.m_sel_o        = '1;
    assign bus.m_cti_o        = cti_q;
    assign bus.m_bte_o        = BTE_LINEAR;
    assign bus.stream_valid_o = ~fifo_empty;

    assign busy   = busy_q;
    assign tx_cnt = tx_cnt_q;
    assign error  = error_q;

endmodule

// File: tb/tb_wb_stream_reader_master.sv
// Randomised scoreboard bench: a transfer model queues expected bus beats and stream words,
// a Wishbone slave and a stream sink pop and compare as the DUT presents them.
module tb_wb_stream_reader_master;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] start_adr;
    logic [AW-1:0] buf_size;
    logic [AW-1:0] burst_size;
    logic          busy;
    logic [DW-1:0] tx_cnt;
    logic          error;

    wb_stream_reader_master_if #(.WB_AW(AW), .WB_DW(DW)) bus_if ();

    wb_stream_reader_master #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(5)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .enable     (enable),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size),
        .busy       (busy),
        .tx_cnt     (tx_cnt),
        .error      (error),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    beat_t       exp_beat_q[$];
    logic [31:0] exp_word_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int ack_pct = 100;
    int ready_mode = 1;
    int err_beat = 0;
    int beat_idx = 0;
    int last_pop_cycle = 0;
    bit err_pend = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transfer model: split the job into bursts of min(clamped burst, remaining) words.
    task automatic model_xfer(input logic [31:0] adr, input logic [31:0] bsz,
                              input logic [31:0] bst, input int errb, output int nwords);
        int          rem, blen, n, beat;
        logic [31:0] a;
        beat_t       e;
        nwords = 0;
        beat   = 0;
        rem    = int'(bsz);
        a      = adr & 32'hFFFF_FFFC;
        blen   = (bst == 0) ? 1 : (bst > 32) ? 32 : int'(bst);
        while (rem > 0) begin
            n = (rem < blen) ? rem : blen;
            for (int i = 0; i < n; i++) begin
                beat++;
                e.adr = a;
                e.cti = (i == n - 1) ? 3'b111 : 3'b010;
                exp_beat_q.push_back(e);
                if (beat == errb) return;
                exp_word_q.push_back(mem_word(a));
                nwords++;
                a += 32'd4;
            end
            rem -= n;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Wishbone slave: decides ack/err at the falling edge, the DUT samples it at the next rise.
    initial begin
        beat_t e;
        bus_if.m_ack_i = 1'b0;
        bus_if.m_err_i = 1'b0;
        bus_if.m_dat_i = '0;
        forever begin
            @(negedge clk);
            bus_if.m_ack_i = 1'b0;
            bus_if.m_err_i = 1'b0;
            if (err_pend) begin
                check("cyc_drop_after_err", bus_if.m_cyc_o, 0);
                err_pend = 1'b0;
            end
            if (rst_n && bus_if.m_cyc_o && bus_if.m_stb_o &&
                ($urandom_range(0, 99) < ack_pct)) begin
                beat_idx++;
                check("beat_expected", exp_beat_q.size() != 0, 1);
                if (exp_beat_q.size() != 0) begin
                    e = exp_beat_q.pop_front();
                    check("beat_adr", bus_if.m_adr_o, e.adr);
                    check("beat_cti", bus_if.m_cti_o, e.cti);
                end
                check("beat_we_sel_bte", {bus_if.m_we_o, bus_if.m_sel_o, bus_if.m_bte_o}, 7'b0_1111_00);
                if (beat_idx == err_beat) begin
                    bus_if.m_err_i = 1'b1;
                    err_pend = 1'b1;
                end else begin
                    bus_if.m_ack_i = 1'b1;
                    bus_if.m_dat_i = mem_word(bus_if.m_adr_o);
                end
            end
        end
    end

    // Stream sink: the head word must match whenever valid; a pop happens when ready is also set.
    initial begin
        bus_if.stream_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus_if.stream_ready_i = 1'b0;
                1:       bus_if.stream_ready_i = 1'b1;
                default: bus_if.stream_ready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (rst_n && bus_if.stream_valid_o) begin
                check("word_expected", exp_word_q.size() != 0, 1);
                if (exp_word_q.size() != 0) begin
                    check("stream_data", bus_if.stream_data_o, exp_word_q[0]);
                    if (bus_if.stream_ready_i) begin
                        void'(exp_word_q.pop_front());
                        last_pop_cycle = cyc_cnt;
                    end
                end
            end
        end
    end

    task automatic start_xfer(input logic [31:0] adr, input logic [31:0] bsz,
                              input logic [31:0] bst, input int errb, input bit hold,
                              output int nwords);
        model_xfer(adr, bsz, bst, errb, nwords);
        err_beat = errb;
        beat_idx = 0;
        @(negedge clk);
        start_adr  = adr;
        buf_size   = bsz;
        burst_size = bst;
        enable     = 1'b1;
        @(negedge clk);
        start_adr  = $urandom;
        buf_size   = $urandom_range(1, 100);
        burst_size = $urandom;
        if (!hold) enable = 1'b0;
    endtask

    task automatic finish_xfer(input int nwords, input bit exp_err, input string tag);
        for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
        check({tag, "_busy_fall"}, busy, 0);
        if (!exp_err && nwords > 0)
            check({tag, "_busy_fall_after_last_word"}, cyc_cnt - last_pop_cycle, 1);
        repeat (5) @(negedge clk);
        check({tag, "_tx_cnt"}, tx_cnt, nwords);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_words_left"}, exp_word_q.size(), 0);
        check({tag, "_beats_left"}, exp_beat_q.size(), 0);
        check({tag, "_cyc_idle"}, bus_if.m_cyc_o, 0);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nw, cnt_a, cnt_b;
        logic [31:0] radr, rbsz, rbst;
        int errb;

        rst_n = 1'b0;
        enable = 1'b0;
        start_adr = '0;
        buf_size = '0;
        burst_size = '0;
        repeat (3) @(negedge clk);
        check("rst_cyc", bus_if.m_cyc_o, 0);
        check("rst_stb", bus_if.m_stb_o, 0);
        check("rst_adr", bus_if.m_adr_o, 0);
        check("rst_cti", bus_if.m_cti_o, 0);
        check("rst_we_sel_bte", {bus_if.m_we_o, bus_if.m_sel_o, bus_if.m_bte_o}, 7'b0_1111_00);
        check("rst_valid", bus_if.stream_valid_o, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_cnt", tx_cnt, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: two 4-beat bursts
        ack_pct = 100; ready_mode = 1;
        start_xfer(32'h100, 8, 4, 0, 0, nw);
        finish_xfer(nw, 0, "t1");

        // 2: 4,4,2 with slow slave and a hesitant sink
        ack_pct = 60; ready_mode = 2;
        start_xfer(32'h200, 10, 4, 0, 0, nw);
        finish_xfer(nw, 0, "t2");

        // 3: sink stalled, first burst fills the FIFO and nothing else starts
        ack_pct = 80; ready_mode = 0;
        start_xfer(32'h2000, 64, 32, 0, 0, nw);
        for (int i = 0; i < 2000 && beat_idx < 32; i++) @(negedge clk);
        check("t3_first_burst_beats", beat_idx, 32);
        cnt_a = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_if.m_cyc_o) cnt_a++;
        end
        check("t3_no_second_cyc", cnt_a, 0);
        check("t3_valid_held", bus_if.stream_valid_o, 1);
        ready_mode = 2;
        finish_xfer(nw, 0, "t3");

        // 4: bus error on beat 3
        ack_pct = 100; ready_mode = 1;
        start_xfer(32'h100, 8, 4, 3, 0, nw);
        finish_xfer(nw, 1, "t4");
        check("t4_words_delivered", nw, 2);

        // 5: zero length ignored, then burst 0 means single beats
        start_xfer(32'h400, 0, 4, 0, 0, nw);
        cnt_a = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) cnt_a++;
        end
        check("t5_busy_buf0", cnt_a, 0);
        check("t5_beats_buf0", beat_idx, 0);
        start_xfer(32'h500, 3, 0, 0, 0, nw);
        finish_xfer(nw, 0, "t5");

        // 6: reset mid-burst with enable held high across it
        ack_pct = 50;
        start_xfer(32'h3000, 16, 8, 0, 1, nw);
        for (int i = 0; i < 200 && !bus_if.m_cyc_o; i++) @(negedge clk);
        check("t6_cyc_before_reset", bus_if.m_cyc_o, 1);
        #2 rst_n = 1'b0;
        exp_beat_q.delete();
        exp_word_q.delete();
        #1;
        check("t6_async_cyc", bus_if.m_cyc_o, 0);
        check("t6_async_stb", bus_if.m_stb_o, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_valid", bus_if.stream_valid_o, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) cnt_a++;
            if (bus_if.m_cyc_o) cnt_b++;
        end
        check("t6_no_restart_busy", cnt_a, 0);
        check("t6_no_restart_cyc", cnt_b, 0);
        enable = 1'b0;
        @(negedge clk);
        start_xfer(32'h3100, 5, 2, 0, 0, nw);
        finish_xfer(nw, 0, "t6");

        // 7: address wraps past the top of the space
        ack_pct = 100; ready_mode = 2;
        start_xfer(32'hFFFF_FFF8, 6, 4, 0, 0, nw);
        finish_xfer(nw, 0, "t7");

        // Random transfers, occasionally aborted by a bus error
        for (int t = 0; t < 14; t++) begin
            radr = $urandom;
            rbsz = $urandom_range(1, 70);
            rbst = $urandom_range(0, 40);
            errb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rbsz)) : 0;
            ack_pct = $urandom_range(30, 100);
            ready_mode = $urandom_range(1, 2);
            start_xfer(radr, rbsz, rbst, errb, 0, nw);
            finish_xfer(nw, errb != 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
